// File: rtl/vga_timing_controller.sv
// ---------------------------------------------------------------------------
// vga_timing_controller
//
// Generates the raster scan for the VGA output path. Two counters step
// through every pixel of every line. HSYNC, VSYNC and the line/frame strobes
// are decoded from those counter values.
//
// RUN starts the raster. When RUN drops, the scan stops only after the
// current frame finishes, so the monitor never sees a truncated frame.
//
// All outputs are registered. Each output describes the counter value that
// is presented in the same cycle.
//
// Ports:
//   PIX_CLK      in   1   pixel clock, rising edge
//   RST_N        in   1   asynchronous active-low reset
//   RUN          in   1   level request to scan (0 = stop at end of frame)
//   ACTIVE       out  1   high while RUNNING or STOPPING
//   HORIZONTAL   out  11  pixel column, 0..H_TOTAL-1
//   VERTICAL     out  11  line, 0..V_TOTAL-1
//   HSYNC        out  1   horizontal sync, active level H_POL
//   VSYNC        out  1   vertical sync, active level V_POL
//   LINE_START   out  1   one-cycle strobe at HORIZONTAL == 0
//   FRAME_START  out  1   one-cycle strobe at (0,0)
//   FRAME_CNT    out  16  completed-frame counter (wraps at 2^16)
// ---------------------------------------------------------------------------
module vga_timing_controller #(
    parameter int H_RES  = 1024,
    parameter int H_FP   = 24,
    parameter int H_SYNC = 136,
    parameter int H_BP   = 160,
    parameter int V_RES  = 768,
    parameter int V_FP   = 3,
    parameter int V_SYNC = 6,
    parameter int V_BP   = 29,
    parameter bit H_POL  = 1'b0,
    parameter bit V_POL  = 1'b0
) (
    input  logic        PIX_CLK,
    input  logic        RST_N,
    input  logic        RUN,
    output logic        ACTIVE,
    output logic [10:0] HORIZONTAL,
    output logic [10:0] VERTICAL,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        LINE_START,
    output logic        FRAME_START,
    output logic [15:0] FRAME_CNT
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    // The 11-bit counters can only cover totals up to 2048.
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_totals
        $error("vga_timing_controller: H_TOTAL/V_TOTAL exceed 2048");
    end

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

    // Sync windows are half-open [start, end).
    // The window ends are widened to 12 bits because a window can end at 2048.
    localparam logic [11:0] H_SYNC_START = 12'(H_RES + H_FP);
    localparam logic [11:0] H_SYNC_END   = 12'(H_RES + H_FP + H_SYNC);
    localparam logic [11:0] V_SYNC_START = 12'(V_RES + V_FP);
    localparam logic [11:0] V_SYNC_END   = 12'(V_RES + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUNNING  = 2'd1,
        S_STOPPING = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [10:0] h_q, h_d;
    logic [10:0] v_q, v_d;
    logic        active_q;
    logic        hsync_q;
    logic        vsync_q;
    logic        line_start_q;
    logic        frame_start_q;
    logic [15:0] frame_cnt_q;

    logic        end_of_line;
    logic        end_of_frame;
    logic        frame_done;
    logic        scan_d;

    // True when pos lies in the half-open window [lo, hi).
    function automatic logic in_window(input logic [10:0] pos,
                                       input logic [11:0] lo,
                                       input logic [11:0] hi);
        return ({1'b0, pos} >= lo) && ({1'b0, pos} < hi);
    endfunction

    // Next-state and next-counter decode.
    // In IDLE the counters are forced to 0. Leaving IDLE therefore always
    // presents (0,0) on the first scanning cycle.
    always_comb begin
        end_of_line  = (h_q == H_LAST);
        end_of_frame = end_of_line && (v_q == V_LAST);
        state_d      = state_q;
        h_d          = 11'd0;
        v_d          = 11'd0;
        frame_done   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (RUN) begin
                    state_d = S_RUNNING;
                end
            end

            S_RUNNING, S_STOPPING: begin
                h_d        = end_of_line ? 11'd0 : h_q + 11'd1;
                v_d        = end_of_line ? (end_of_frame ? 11'd0 : v_q + 11'd1) : v_q;
                frame_done = end_of_frame;

                if (state_q == S_RUNNING) begin
                    if (!RUN) begin
                        state_d = S_STOPPING;
                    end
                end else begin
                    // A re-raised RUN wins over the frame boundary.
                    // The scan then simply wraps and keeps running.
                    if (RUN) begin
                        state_d = S_RUNNING;
                    end else if (end_of_frame) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        scan_d = (state_d != S_IDLE);
    end

    // All outputs are decoded from the next counter values and then
    // registered. Each registered output therefore lines up with the counter
    // value it describes, and no combinational path reaches a pin.
    always_ff @(posedge PIX_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= S_IDLE;
            h_q           <= 11'd0;
            v_q           <= 11'd0;
            active_q      <= 1'b0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            active_q      <= scan_d;
            line_start_q  <= scan_d && (h_d == 11'd0);
            frame_start_q <= scan_d && (h_d == 11'd0) && (v_d == 11'd0);
            hsync_q       <= (scan_d && in_window(h_d, H_SYNC_START, H_SYNC_END)) ? H_POL : ~H_POL;
            // v_d only changes when h_d wraps to 0.
            // VSYNC therefore moves on the line boundary.
            vsync_q       <= (scan_d && in_window(v_d, V_SYNC_START, V_SYNC_END)) ? V_POL : ~V_POL;
            if (frame_done) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign ACTIVE      = active_q;
    assign HORIZONTAL  = h_q;
    assign VERTICAL    = v_q;
    assign HSYNC       = hsync_q;
    assign VSYNC       = vsync_q;
    assign LINE_START  = line_start_q;
    assign FRAME_START = frame_start_q;
    assign FRAME_CNT   = frame_cnt_q;

endmodule
